// File: rtl/bram0_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bram0_stream_loader
//  Description : Fill stage for the accessor's input memory (BRAM0). Accepts
//                an element stream over valid/ready, packs LANES elements per
//                DWIDTH-bit word (lane 0 in the LSBs) and writes a programmed
//                number of words to BRAM0 port B starting at address 0.
//                done_o pulses once when the transfer completes and is meant
//                to drive the downstream accessor's start_run_i.
//  Ports       : clk, reset          - clock, async active-high reset
//                start_load_i        - start pulse (honoured in IDLE only)
//                load_count_i        - words to write (clamped to MEM_SIZE)
//                s_valid_i/s_data_i  - stream input
//                s_ready_o           - stream ready
//                idle_o/load_o       - FSM state flags
//                done_o              - one-cycle completion pulse
//                addr_b0_o, ce_b0_o, we_b0_o, d_b0_o - BRAM0 port B write
//  Revision    : 1.0 - initial release
// ============================================================================
module bram0_stream_loader #(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 8,
    parameter int MEM_SIZE      = 256,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_load_i,
    input  logic [CNT_BIT-1:0]       load_count_i,
    input  logic                     s_valid_i,
    input  logic [IN_DATA_WIDTH-1:0] s_data_i,
    output logic                     s_ready_o,
    output logic                     idle_o,
    output logic                     load_o,
    output logic                     done_o,
    output logic [AWIDTH-1:0]        addr_b0_o,
    output logic                     ce_b0_o,
    output logic                     we_b0_o,
    output logic [DWIDTH-1:0]        d_b0_o
);

    localparam int LANES = DWIDTH / IN_DATA_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    // Count register must be able to hold MEM_SIZE itself (a full memory).
    localparam int CW    = $clog2(MEM_SIZE + 1);

    localparam logic [CNT_BIT-1:0] c_MEM_SIZE_CNT = CNT_BIT'(MEM_SIZE);
    localparam logic [LW-1:0]      c_LAST_LANE    = LW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_words;      // words fully accepted so far
    logic [LW-1:0]       r_lane;
    logic [DWIDTH-1:0]   r_pack;
    logic                r_ce;
    logic                r_we;
    logic                r_done;
    logic [AWIDTH-1:0]   r_addr;
    logic [DWIDTH-1:0]   r_data;

    logic [CW-1:0]       w_eff_count;
    logic [DWIDTH-1:0]   w_pack_next;
    logic                w_hs;

    // Clamp so the address never wraps past the end of BRAM0.
    assign w_eff_count = (load_count_i > c_MEM_SIZE_CNT) ? CW'(MEM_SIZE)
                                                         : CW'(load_count_i);

    // Ready depends only on registered state, never on s_valid_i.
    assign s_ready_o = (r_state == S_LOAD) && (r_words < r_count);
    assign w_hs      = s_valid_i && s_ready_o;

    // Pack register with the incoming element merged into the current lane,
    // so the completing element goes straight into the write data.
    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[r_lane*IN_DATA_WIDTH +: IN_DATA_WIDTH] = s_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_words <= '0;
            r_lane  <= '0;
            r_pack  <= '0;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_ce   <= 1'b0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_load_i) begin
                        r_count <= w_eff_count;
                        r_words <= '0;
                        r_lane  <= '0;
                        r_pack  <= '0;
                        if (w_eff_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // The final strobe is on the outputs this cycle; ready is
                    // already low, so no handshake can coincide with it.
                    if (r_we && (r_words == r_count)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_hs) begin
                        if (r_lane == c_LAST_LANE) begin
                            r_ce    <= 1'b1;
                            r_we    <= 1'b1;
                            r_addr  <= AWIDTH'(r_words);
                            r_data  <= w_pack_next;
                            r_words <= r_words + CW'(1);
                            r_lane  <= '0;
                            r_pack  <= '0;
                        end else begin
                            r_lane  <= r_lane + LW'(1);
                            r_pack  <= w_pack_next;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign idle_o    = (r_state == S_IDLE);
    assign load_o    = (r_state == S_LOAD);
    assign done_o    = r_done;
    assign ce_b0_o   = r_ce;
    assign we_b0_o   = r_we;
    assign addr_b0_o = r_addr;
    assign d_b0_o    = r_data;

endmodule
`default_nettype wire

// File: doc/bram0_stream_loader.md
Name: bram0_stream_loader

Overview:
- Upstream fill stage for BRAM_accessor's input memory (BRAM0, DWIDTH-wide words).
- Accepts a byte stream over a valid/ready handshake and packs IN_DATA_WIDTH-bit elements into DWIDTH-bit words.
- Writes a programmed number of words to BRAM0 port B, starting at address 0.
- done_o is the trigger for start_run_i of the downstream accessor.

Parameters:
CNT_BIT, 31, width of the word-count input
DWIDTH, 32, BRAM0 data width
AWIDTH, 8, BRAM0 address width
MEM_SIZE, 256, BRAM0 depth in words
IN_DATA_WIDTH, 8, stream element width; LANES = DWIDTH/IN_DATA_WIDTH (4 by default)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start_load_i  in  1  one-cycle start pulse, sampled only in IDLE
load_count_i  in  CNT_BIT  number of words to write, sampled with start
s_valid_i  in  1  stream element valid
s_data_i  in  IN_DATA_WIDTH  stream element
s_ready_o  out  1  loader can accept an element this cycle
idle_o  out  1  FSM in IDLE
load_o  out  1  FSM in LOAD
done_o  out  1  one-cycle completion pulse
addr_b0_o  out  AWIDTH  BRAM0 write address
ce_b0_o  out  1  BRAM0 chip enable
we_b0_o  out  1  BRAM0 write enable
d_b0_o  out  DWIDTH  BRAM0 write data

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - All counters and the pack register clear.
  - ce_b0_o=0, we_b0_o=0, addr_b0_o=0, d_b0_o=0, done_o=0, s_ready_o=0.
  - idle_o=1, load_o=0.
  - Reset during LOAD abandons the transfer; no further writes occur.
- FSM has three states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start_load_i=1.
  - IDLE -> DONE instead if the effective count is 0.
  - LOAD -> DONE on the cycle after the final word's write strobe.
  - DONE -> IDLE unconditionally after 1 cycle.
  - start_load_i outside IDLE is ignored.
- Effective count = min(load_count_i, MEM_SIZE), latched at start. Values above MEM_SIZE are clamped; addresses never wrap.
- s_ready_o = (state==LOAD) && (words_accepted < count). It is combinational from registered state only, with no dependence on s_valid_i.
- Handshake occurs when s_valid_i && s_ready_o on a rising edge.
  - Element k (k=0..LANES-1) of a word lands in bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH]; lane 0 is the LSB.
  - The lane counter advances only on a handshake; gaps in s_valid_i are allowed.
- Write timing:
  - The handshake completing lane LANES-1 occurs at edge T.
  - In the following cycle, ce_b0_o=we_b0_o=1 for exactly one cycle, with addr_b0_o=word index and d_b0_o=packed word. These are registered outputs.
  - The lane counter resets, and the word index increments after the write.
  - Writes are back-to-back at most once every LANES cycles.
- End of transfer:
  - s_ready_o drops in the cycle following the last accepted element.
  - The final write strobe occurs at T+1.
  - done_o=1 at T+2, and idle_o=1 at T+3.
- Outside write cycles: ce_b0_o=we_b0_o=0. addr_b0_o and d_b0_o hold their last values.
- Extra stream elements after the count is reached are not accepted (s_ready_o=0).

Test Plan:
1. Reset asserted mid-cycle -> all outputs go to reset values immediately (asynchronous); idle_o=1.
2. start with count=2, stream 0x01..0x08 continuously -> writes addr0=0x04030201, addr1=0x08070605; done_o pulses once at the cycle after the second strobe; exactly 2 strobes occur.
3. count=1 with s_valid_i toggling 1,0,1,0,... -> one write at addr0 containing 4 bytes in order; no write before the 4th handshake.
4. count=0 -> no BRAM strobes; s_ready_o stays 0; done_o is asserted the cycle after start; idle_o returns the next cycle.
5. count=300 (>MEM_SIZE), stream 1024 bytes of 0x01 -> exactly 256 writes of 0x01010101 at addr 0..255; s_ready_o=0 after the 1024th byte; done_o is a single pulse.
6. Reset asserted after 5 bytes of a count=4 transfer, then a restart with count=1 -> the restart writes addr0 from fresh bytes only; the stale partial word is never written.
